// File: rtl/uart_tx_top.sv
// Transmit-side UART: byte FIFO feeding an 8N1-style serializer.
// The baud generator is external and shared, so b_en requests it only
// while a frame is in flight. b_clk pulses are counted B_TICK per bit.
module uart_tx_top #(
    parameter int D_W    = 8,
    parameter int B_TICK = 16,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     b_clk,
    output logic                     b_en,
    input  logic                     wr_en,
    input  logic [D_W-1:0]           data_in,
    output logic                     ff_full,
    output logic                     ff_empty,
    output logic [$clog2(DEPTH):0]   ff_count,
    output logic                     wr_ovf,
    output logic                     tx_data,
    output logic                     tx_busy,
    output logic                     tx_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
    localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [D_W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q, count_d;
    logic           full_q, empty_q, ovf_q;
    logic [D_W-1:0] rd_data_q;

    logic [2:0]     state_q, state_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [D_W-1:0] shreg_q, shreg_d;

    logic push, pop, tick_last;

    // Last baud tick of the current bit period.
    assign tick_last = b_clk && (tick_q == TW'(B_TICK - 1));
    // Writes are judged on the registered full flag: a same-cycle pop never makes room.
    assign push = wr_en && !full_q;
    assign pop  = !empty_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && tick_last));

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO control: pointers, occupancy, flags registered from the next count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
            ovf_q   <= wr_en && full_q;
        end
    end

    // FIFO storage and registered read port; the popped word is valid in LOAD.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= data_in;
        if (pop)  rd_data_q     <= mem[rd_ptr_q];
    end

    // Serializer next-state: tick/bit counting and LSB-first shifting.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (pop) state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = rd_data_q;
                tick_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (tick_last) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else if (b_clk) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    tick_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BW'(D_W - 1)) state_d = S_STOP;
                    else                       bit_d   = bit_q + 1'b1;
                end else if (b_clk) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tick_last) begin
                    tick_d  = '0;
                    state_d = pop ? S_LOAD : S_IDLE;
                end else if (b_clk) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Serializer control state; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
        end
    end

    // Shift register holds payload only, so it carries no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    // Line and status decode straight from state so reset forces the line high at once.
    assign tx_data  = (state_q == S_START) ? 1'b0 :
                      (state_q == S_DATA)  ? shreg_q[0] : 1'b1;
    assign tx_busy  = (state_q != S_IDLE);
    assign b_en     = (state_q != S_IDLE);
    assign tx_done  = (state_q == S_STOP) && tick_last;
    assign ff_full  = full_q;
    assign ff_empty = empty_q;
    assign ff_count = count_q;
    assign wr_ovf   = ovf_q;
endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: a frame-level reference model (byte queue plus a
// tick position within the current frame) is compared every cycle, and
// directed scenarios add hand-computed expectations.
module tb_uart_tx_top;
    localparam int D_W = 8, B_TICK = 16, DEPTH = 64;
    localparam int FRAME_TICKS = (D_W + 2) * B_TICK;

    logic clk = 1'b0, rst = 1'b0, b_clk = 1'b0, wr_en = 1'b0;
    logic [D_W-1:0] data_in = '0;
    logic b_en, ff_full, ff_empty, wr_ovf, tx_data, tx_busy, tx_done;
    logic [$clog2(DEPTH):0] ff_count;

    uart_tx_top #(.D_W(D_W), .B_TICK(B_TICK), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .b_clk(b_clk), .b_en(b_en),
        .wr_en(wr_en), .data_in(data_in),
        .ff_full(ff_full), .ff_empty(ff_empty), .ff_count(ff_count),
        .wr_ovf(wr_ovf), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    bit chk_on = 0;
    int b_mode = 0;
    int bdiv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Baud tick source: 0 = off, N = one pulse every N cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (b_mode <= 0) b_clk = 1'b0;
        else begin
            if (bdiv >= b_mode - 1) bdiv = 0;
            else bdiv++;
            b_clk = (bdiv == 0);
        end
    end

    // ---------------- reference model ----------------
    logic [D_W-1:0] mq[$];
    bit m_act, m_load, m_ovf;
    int m_ticks;
    logic [D_W-1:0] m_byte;
    bit md, mp, ma;

    function automatic bit m_done();
        return m_act && !m_load && b_clk && (m_ticks == FRAME_TICKS - 1);
    endfunction

    function automatic logic m_tx();
        int b;
        if (!m_act || m_load) return 1'b1;
        b = m_ticks / B_TICK;
        if (b == 0) return 1'b0;
        if (b <= D_W) return m_byte[b-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_act = 0; m_load = 0; m_ovf = 0; m_ticks = 0;
        end else begin
            md = m_done();
            mp = (mq.size() > 0) && (!m_act || md);
            ma = wr_en && (mq.size() < DEPTH);
            m_ovf = wr_en && !ma;
            if (mp) begin
                m_byte = mq.pop_front();
                m_act = 1; m_load = 1; m_ticks = 0;
            end else if (md) m_act = 0;
            else if (m_load) m_load = 0;
            else if (m_act && b_clk) m_ticks++;
            if (ma) mq.push_back(data_in);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("m_tx_data",  tx_data,  m_tx());
            check("m_tx_busy",  tx_busy,  m_act);
            check("m_b_en",     b_en,     m_act);
            check("m_tx_done",  tx_done,  m_done());
            check("m_ff_count", ff_count, mq.size());
            check("m_ff_empty", ff_empty, mq.size() == 0);
            check("m_ff_full",  ff_full,  mq.size() == DEPTH);
            check("m_wr_ovf",   wr_ovf,   m_ovf);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [D_W-1:0] v);
        wr_en = 1'b1; data_in = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string nm);
        int n = 0;
        while (!tx_done && n < lim) begin tick(); n++; end
        check(nm, tx_done, 1'b1);
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int n = 0;
        while (!(ff_empty && !tx_busy) && n < lim) begin tick(); n++; end
        check(nm, ff_empty && !tx_busy, 1'b1);
    endtask

    logic [9:0] fr;
    int total, lows, n;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("rst_tx_data", tx_data, 1'b1);
        check("rst_ff_empty", ff_empty, 1'b1);
        check("rst_ff_full", ff_full, 1'b0);
        check("rst_ff_count", ff_count, 0);
        check("rst_b_en", b_en, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_wr_ovf", wr_ovf, 1'b0);
        rst = 1'b1;
        chk_on = 1;
        b_mode = 1;
        repeat (4) tick();

        // Single frame 0xA5 with a tick every cycle
        wr(8'hA5);
        check("t1_idle_c1", tx_busy, 1'b0);
        tick();
        check("t1_load_busy", tx_busy, 1'b1);
        check("t1_load_line", tx_data, 1'b1);
        tick();
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < FRAME_TICKS + 16; i++) begin
            check("t1_line", tx_data, (i < FRAME_TICKS) ? fr[i / B_TICK] : 1'b1);
            check("t1_done", tx_done, i == FRAME_TICKS - 1);
            check("t1_b_en", b_en, i < FRAME_TICKS);
            tick();
        end

        // Back-to-back frames 0x55, 0x0F
        wr_en = 1'b1; data_in = 8'h55; tick();
        data_in = 8'h0F; tick();
        wr_en = 1'b0;
        wait_done(200, "t2_first_done");
        check("t2_empty_before_pop", ff_empty, 1'b0);
        tick();
        check("t2_gap_high", tx_data, 1'b1);
        check("t2_empty_after_pop", ff_empty, 1'b1);
        tick();
        check("t2_second_start", tx_data, 1'b0);
        wait_done(200, "t2_second_done");
        repeat (5) tick();

        // Fill with baud stalled, overflow, then drain; write collides with a pop
        b_mode = 0;
        repeat (2) tick();
        for (int i = 0; i < 66; i++) begin
            wr_en = 1'b1; data_in = 8'(i * 37 + 11);
            tick();
            if (i == 64) begin
                check("t3_count64", ff_count, 64);
                check("t3_full", ff_full, 1'b1);
                check("t3_no_ovf", wr_ovf, 1'b0);
            end
        end
        wr_en = 1'b0;
        check("t3_ovf_pulse", wr_ovf, 1'b1);
        check("t3_count_hold", ff_count, 64);
        check("t3_stalled_start", tx_data, 1'b0);
        tick();
        check("t3_ovf_single", wr_ovf, 1'b0);
        b_mode = 1;
        wait_done(300, "t3_first_done");
        check("t6_full_at_stop", ff_full, 1'b1);
        wr_en = 1'b1; data_in = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("t6_ovf", wr_ovf, 1'b1);
        check("t6_count63", ff_count, 63);
        check("t6_not_full", ff_full, 1'b0);
        wait_idle(66 * (FRAME_TICKS + 4), "t3_drain");
        repeat (5) tick();

        // Slow baud: one tick every 5 cycles, byte 0xFF
        b_mode = 5;
        repeat (3) tick();
        wr(8'hFF);
        n = 0;
        while (tx_data && n < 10) begin tick(); n++; end
        check("t4_start_seen", tx_data, 1'b0);
        total = 0; lows = 0;
        while (!tx_done && total < 900) begin
            if (!tx_data) lows++;
            total++;
            tick();
        end
        total++;
        check("t4_done_seen", tx_done, 1'b1);
        check("t4_len_range", (total >= 796) && (total <= 800), 1'b1);
        check("t4_after_start", total - lows, 720);
        check("t4_start_len", (lows >= 76) && (lows <= 80), 1'b1);
        wait_idle(20, "t4_idle");

        // Reset during data bit 3 of 0x3C with 10 bytes queued
        b_mode = 1;
        repeat (3) tick();
        wr_en = 1'b1; data_in = 8'h3C; tick();
        for (int i = 0; i < 10; i++) begin data_in = 8'(i + 1); tick(); end
        wr_en = 1'b0;
        check("t5_queued", ff_count, 10);
        n = 0;
        while (!(m_act && !m_load && (m_ticks / B_TICK) == 4) && n < 200) begin tick(); n++; end
        check("t5_in_bit3", tx_busy, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_line_high", tx_data, 1'b1);
        check("t5_empty", ff_empty, 1'b1);
        check("t5_count0", ff_count, 0);
        check("t5_not_busy", tx_busy, 1'b0);
        check("t5_b_en_low", b_en, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            check("t5_idle_line", tx_data, 1'b1);
            tick();
        end
        wr(8'h81);
        wait_done(200, "t5_new_done");
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
